output_stream_controller: RTL

Drains the vector CPU's output port into an external element-serial stream. Each `outFlag` strobe captures a 6-element, 19-bit vector into a small FIFO. A serializer emits the elements one per handshake on a valid/ready interface. When the FIFO is full, the block raises a stall request into the CPU hazard unit, so output vectors are never silently lost while the stall is honoured.

---
 rtl/output_stream_controller.sv | 125 ++++++++++++
 1 files changed

// File: rtl/output_stream_controller.sv
// Buffers output vectors from the vector CPU in a small FIFO and serializes them
// element by element onto a valid/ready stream, requesting a CPU stall when full.
module output_stream_controller #(
  parameter int unsigned DATA_WIDTH  = 19,
  parameter int unsigned VECTOR_SIZE = 6,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned INDEX_WIDTH = 3,
  parameter int unsigned COUNT_WIDTH = 3
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              outFlag,
  input  logic [VECTOR_SIZE*DATA_WIDTH-1:0] out,
  output logic                              stallOut,
  output logic                              streamValid,
  output logic [DATA_WIDTH-1:0]             streamData,
  output logic [INDEX_WIDTH-1:0]            streamIndex,
  output logic                              streamLast,
  input  logic                              streamReady,
  output logic [COUNT_WIDTH-1:0]            pending,
  output logic                              overflow
);

  localparam int unsigned VecW = VECTOR_SIZE * DATA_WIDTH;
  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [COUNT_WIDTH-1:0] Full    = COUNT_WIDTH'(FIFO_DEPTH);
  localparam logic [INDEX_WIDTH-1:0] LastIdx = INDEX_WIDTH'(VECTOR_SIZE - 1);

  typedef enum logic {StIdle, StSend} state_e;

  state_e                 state_q, state_d;
  logic [VecW-1:0]        mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic [INDEX_WIDTH-1:0] idx_q, idx_d;
  logic [VecW-1:0]        hold_q;
  logic                   overflow_q;
  logic                   push, pop, not_empty;

  assign not_empty = (count_q != '0);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (not_empty) begin
          pop     = 1'b1;
          idx_d   = '0;
          state_d = StSend;
        end
      end
      StSend: begin
        if (streamReady) begin
          if (idx_q == LastIdx) begin
            // Reload straight from the FIFO so consecutive vectors have no bubble.
            if (not_empty) begin
              pop   = 1'b1;
              idx_d = '0;
            end else begin
              state_d = StIdle;
            end
          end else begin
            idx_d = idx_q + INDEX_WIDTH'(1);
          end
        end
      end
    endcase
  end

  // A full FIFO still accepts when the same cycle frees a slot.
  assign push    = outFlag && ((count_q != Full) || pop);
  assign count_d = count_q + COUNT_WIDTH'(push) - COUNT_WIDTH'(pop);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      idx_q      <= '0;
      hold_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
        hold_q   <= mem_q[rd_ptr_q];
      end
      if (outFlag && !push) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // Storage needs no reset: occupancy is governed entirely by the pointers and count.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= out;
    end
  end

  always_comb begin
    streamValid = (state_q == StSend);
    streamData  = '0;
    streamIndex = '0;
    streamLast  = 1'b0;
    if (streamValid) begin
      streamData  = hold_q[idx_q*DATA_WIDTH +: DATA_WIDTH];
      streamIndex = idx_q;
      streamLast  = (idx_q == LastIdx);
    end
  end

  assign stallOut = (count_q == Full);
  assign pending  = count_q;
  assign overflow = overflow_q;

endmodule
